apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
Shares the single APB master (Transfer/Wr_Rd/Address/write_data/read_data interface) between NUM_REQ requesters using round-robin arbitration. Latches the winning request, drives the master's command inputs until the bus completes, and returns read data with a one-cycle ack to the winner. Snoops PENABLE/PREADY on the APB bus to detect completion. A timeout aborts hung transfers with an error flag.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles in BUSY before abort (>=4)

Ports:
PCLK  in  1  clock, rising-edge
PRESETn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held until its ack
req_wr  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
req_gnt  out  NUM_REQ  one-hot: requester currently owning the master
req_ack  out  NUM_REQ  one-hot, one-cycle pulse on completion or abort
req_rdata  out  DATA_W  read data, valid in the req_ack cycle
req_err  out  1  one-cycle pulse with req_ack when the transfer timed out
Transfer  out  1  to APB master: start/hold transfer
Wr_Rd  out  1  to APB master: 1=write
Address  out  ADDR_W  to APB master
write_data  out  DATA_W  to APB master
read_data  in  DATA_W  from APB master
PENABLE  in  1  snooped from APB bus
PREADY  in  1  snooped from APB bus

Behaviour:
- All outputs registered. While PRESETn=0 at a PCLK edge: state=IDLE, Transfer=0, Wr_Rd=0, Address=0, write_data=0, req_gnt=0, req_ack=0, req_rdata=0, req_err=0, rr pointer=0, timeout count=0. Reset mid-transfer: Transfer drops, no ack issued.
- States: IDLE, BUSY, GAP.
- IDLE: if any req_valid, pick the winner as the first set bit searching from index ptr upward with wrap to 0; on that edge latch the winner's wr/addr/wdata into Wr_Rd/Address/write_data, set req_gnt one-hot, Transfer=1, ptr=winner+1 mod NUM_REQ, count=0, then go BUSY. Latency: req_valid sampled at edge N gives Transfer=1 after edge N. No request: stay IDLE, outputs unchanged except req_ack/req_err cleared.
- BUSY: hold all command outputs constant. Requester changes to addr/wdata/wr/valid are ignored. A deasserted req_valid does not cancel the transfer. count increments each cycle.
  - PENABLE&PREADY sampled 1: capture read_data into req_rdata if Wr_Rd=0 (else req_rdata holds). Pulse req_ack[gnt] for one cycle, req_err=0, Transfer=0, go GAP.
  - Otherwise, if count==TIMEOUT-1: pulse req_ack[gnt] with req_err=1, req_rdata=0, Transfer=0, go GAP.
  - Completion wins over timeout when both occur in the same cycle.
- GAP: exactly one cycle with Transfer=0 so the master returns to idle. Clear req_gnt and req_ack, go IDLE. Back-to-back grants are therefore spaced by at least one Transfer-low cycle.
- Requesters must drop req_valid in the cycle after seeing their ack. A requester still asserting in IDLE is re-arbitrated normally, and round-robin prevents starvation.
- At most one bit of req_gnt/req_ack is ever set. req_ack is never set in IDLE.
- No width arithmetic beyond ptr wrap (modulo NUM_REQ) and count saturation at TIMEOUT-1.

Test Plan:
- Single write: reset 3 cycles; req_valid=4'b0001, wr=1, addr0=32'h0, wdata0=32'hABCDABCD -> Transfer=1, Address=0, write_data=ABCDABCD next cycle. On the PENABLE&PREADY cycle, req_ack=4'b0001 pulses for exactly 1 cycle. Transfer low for 1 cycle.
- Single read: requester 2, addr=32'h1, master read_data=32'hCAFECAFE at completion -> req_ack=4'b0100, req_rdata=CAFECAFE, req_err=0.
- Round-robin: all four req_valid held high with each dropped after its ack -> grant order 0,1,2,3. Then re-raise 0 and 3 with ptr=0 -> order 0,3.
- Fairness wrap: after requester 3 is served, raise 1 and 3 -> 1 is granted first (ptr wrapped to 0).
- Timeout: request with PREADY held 0 -> ack and req_err pulse together exactly TIMEOUT=16 cycles after Transfer rises, req_rdata=0, Transfer drops. A later request completes normally.
- Reset mid-BUSY: assert PRESETn=0 while Transfer=1 -> after the edge, Transfer=0, req_gnt=0, no req_ack. After release, the pending request is re-granted starting from requester 0.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Purpose : round-robin share of one APB master between NUM_REQ requesters, with a hung-transfer timeout.
// Latency : Transfer rises the cycle after req_valid is seen; ack follows the PENABLE&PREADY cycle; there is one GAP cycle between grants.
// Backpres: requesters hold req_valid until ack; a stalled bus is aborted after TIMEOUT cycles with req_err.
//
// Ports:
//   PCLK, PRESETn           clock and synchronous active-low reset
//   req_valid/wr/addr/wdata per-requester command, packed at [i*W +: W]
//   req_gnt, req_ack        one-hot owner and one-cycle completion pulse
//   req_rdata, req_err      read data and timeout flag, valid with req_ack
//   Transfer/Wr_Rd/Address/write_data/read_data  APB master command side
//   PENABLE, PREADY         snooped from the APB bus to detect completion
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_gnt,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       req_err,
    output logic                       Transfer,
    output logic                       Wr_Rd,
    output logic [ADDR_W-1:0]          Address,
    output logic [DATA_W-1:0]          write_data,
    input  logic [DATA_W-1:0]          read_data,
    input  logic                       PENABLE,
    input  logic                       PREADY
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   count;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_next;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_wr;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    // Requester index visited at step k of a search that starts at p.
    function automatic int rr_idx(input int p, input int k);
        return (p + k) % NUM_REQ;
    endfunction

    // Priority search starting at ptr and wrapping; the first hit wins.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        win_wr    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[rr_idx(int'(ptr), k)]) begin
                found                        = 1'b1;
                win_idx                      = PTR_W'(rr_idx(int'(ptr), k));
                win_oh[rr_idx(int'(ptr), k)] = 1'b1;
                win_wr                       = req_wr[rr_idx(int'(ptr), k)];
                win_addr  = req_addr[rr_idx(int'(ptr), k)*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[rr_idx(int'(ptr), k)*DATA_W +: DATA_W];
            end
        end
    end

    assign win_next = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state      <= IDLE;
            ptr        <= '0;
            count      <= '0;
            Transfer   <= 1'b0;
            Wr_Rd      <= 1'b0;
            Address    <= '0;
            write_data <= '0;
            req_gnt    <= '0;
            req_ack    <= '0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ack <= '0;
                    req_err <= 1'b0;
                    if (found) begin
                        Wr_Rd      <= win_wr;
                        Address    <= win_addr;
                        write_data <= win_wdata;
                        req_gnt    <= win_oh;
                        Transfer   <= 1'b1;
                        ptr        <= win_next;
                        count      <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // Command outputs stay frozen; requester inputs are ignored here.
                    if (count != CNT_MAX)
                        count <= count + CNT_W'(1);
                    if (PENABLE && PREADY) begin
                        // Completion takes priority over a coincident timeout.
                        if (!Wr_Rd)
                            req_rdata <= read_data;
                        req_ack  <= req_gnt;
                        req_err  <= 1'b0;
                        Transfer <= 1'b0;
                        state    <= GAP;
                    end else if (count == CNT_MAX) begin
                        req_ack   <= req_gnt;
                        req_err   <= 1'b1;
                        req_rdata <= '0;
                        Transfer  <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // One Transfer-low cycle lets the APB master fall back to idle.
                    req_gnt <= '0;
                    req_ack <= '0;
                    req_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [3:0]  req_valid, req_wr;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]  req_gnt, req_ack;
    logic [31:0] req_rdata;
    logic        req_err;
    logic        Transfer, Wr_Rd;
    logic [31:0] Address, write_data, read_data;
    logic        PENABLE, PREADY;

    apb_req_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
        .Transfer(Transfer), .Wr_Rd(Wr_Rd), .Address(Address), .write_data(write_data),
        .read_data(read_data), .PENABLE(PENABLE), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   t_grant = 0;
    int   apb_cnt = 0;
    int   wait_st = 0;
    logic hang = 1'b0;
    logic prev_ack = 1'b0;
    logic prev_xfer = 1'b0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return 32'hCAFECAFF ^ a;
    endfunction

    task automatic push_exp(input int idx);
        exp_t e;
        e.idx   = idx;
        e.wr    = req_wr[idx];
        e.addr  = req_addr[idx*32 +: 32];
        e.wdata = req_wdata[idx*32 +: 32];
        e.err   = hang;
        e.lat   = hang ? 16 : 2 + wait_st;
        sb.push_back(e);
    endtask

    task automatic raise(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        req_valid[idx]          = 1'b1;
        req_wr[idx]             = wr;
        req_addr[idx*32 +: 32]  = a;
        req_wdata[idx*32 +: 32] = wd;
        push_exp(idx);
    endtask

    // One cycle: monitor/scoreboard on the negedge, then requester drop and APB bus model.
    task automatic tick();
        exp_t        e;
        logic [31:0] exp_rd;
        logic [3:0]  oh;
        @(negedge PCLK);
        cyc++;
        if (prev_ack) begin
            chk("ack_pulse", {28'd0, req_ack}, 32'd0);
            chk("gap_xfer", {31'd0, Transfer}, 32'd0);
        end
        if (Transfer && !prev_xfer) begin
            if (sb.size() == 0) begin
                chk("grant_unexp", {28'd0, req_gnt}, 32'd0);
            end else begin
                e  = sb[0];
                oh = 4'b0001 << e.idx;
                chk("gnt", {28'd0, req_gnt}, {28'd0, oh});
                chk("wr_rd", {31'd0, Wr_Rd}, {31'd0, e.wr});
                chk("addr", Address, e.addr);
                chk("wdata", write_data, e.wdata);
                t_grant = cyc;
            end
        end
        if (req_ack != 4'd0) begin
            if (sb.size() == 0) begin
                chk("ack_unexp", {28'd0, req_ack}, 32'd0);
            end else begin
                e      = sb.pop_front();
                oh     = 4'b0001 << e.idx;
                exp_rd = e.err ? 32'd0 : (e.wr ? last_rdata : rd_of(e.addr));
                chk("ack", {28'd0, req_ack}, {28'd0, oh});
                chk("err", {31'd0, req_err}, {31'd0, e.err});
                chk("rdata", req_rdata, exp_rd);
                chk("lat", 32'(cyc - t_grant), 32'(e.lat));
                chk("xfer_at_ack", {31'd0, Transfer}, 32'd0);
                last_rdata = exp_rd;
            end
            req_valid = req_valid & ~req_ack;
        end
        prev_ack  = (req_ack != 4'd0);
        prev_xfer = Transfer;
        if (!Transfer) begin
            apb_cnt = 0;
            PENABLE = 1'b0;
            PREADY  = 1'b0;
        end else begin
            apb_cnt++;
            PENABLE = (apb_cnt >= 2);
            PREADY  = !hang && (apb_cnt >= 2 + wait_st);
        end
        read_data = rd_of(Address);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (sb.size() != 0 || Transfer || prev_ack); i++)
            tick();
        chk("drain", 32'(sb.size()), 32'd0);
        tick();
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        read_data = '0;
        PENABLE   = 1'b0;
        PREADY    = 1'b0;
        repeat (3) tick();
        chk("rst_xfer", {31'd0, Transfer}, 32'd0);
        chk("rst_gnt", {28'd0, req_gnt}, 32'd0);
        chk("rst_ack", {28'd0, req_ack}, 32'd0);
        chk("rst_err", {31'd0, req_err}, 32'd0);
        chk("rst_rdata", req_rdata, 32'd0);
        chk("rst_addr", Address, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_wrrd", {31'd0, Wr_Rd}, 32'd0);
        PRESETn = 1'b1;
        tick();

        // Single write from requester 0, then single read from requester 2.
        raise(0, 1'b1, 32'h0, 32'hABCDABCD);
        drain(40);
        raise(2, 1'b0, 32'h1, 32'h0);
        drain(40);

        // Requester 3 with wait states brings the pointer back to 0.
        wait_st = 3;
        raise(3, 1'b1, 32'h300, 32'h33333333);
        drain(40);

        // All four: 0,1,2,3.
        wait_st = 1;
        raise(0, 1'b0, 32'h10, 32'h0);
        raise(1, 1'b1, 32'h14, 32'h11111111);
        raise(2, 1'b0, 32'h18, 32'h0);
        raise(3, 1'b1, 32'h1C, 32'h44444444);
        drain(80);

        // Pointer at 0: requesters 0 and 3 -> 0,3.
        wait_st = 0;
        raise(0, 1'b1, 32'h20, 32'h55555555);
        raise(3, 1'b0, 32'h2C, 32'h0);
        drain(40);

        // After 3 served, pointer wrapped to 0: requesters 1 and 3 -> 1,3.
        raise(1, 1'b0, 32'h34, 32'h0);
        raise(3, 1'b1, 32'h3C, 32'h66666666);
        drain(40);

        // Timeout on a hung bus, then a normal transfer.
        hang = 1'b1;
        raise(1, 1'b0, 32'h44, 32'h0);
        drain(60);
        hang = 1'b0;
        raise(0, 1'b0, 32'h40, 32'h0);
        drain(40);

        // Reset during BUSY: pointer returns to 0, so 2 precedes 3.
        hang = 1'b1;
        raise(2, 1'b0, 32'h58, 32'h0);
        repeat (5) tick();
        chk("busy_before_rst", {31'd0, Transfer}, 32'd1);
        raise(3, 1'b1, 32'h5C, 32'h77777777);
        tick();
        PRESETn = 1'b0;
        tick();
        chk("midrst_xfer", {31'd0, Transfer}, 32'd0);
        chk("midrst_gnt", {28'd0, req_gnt}, 32'd0);
        chk("midrst_ack", {28'd0, req_ack}, 32'd0);
        sb.delete();
        last_rdata = '0;
        hang       = 1'b0;
        wait_st    = 0;
        PRESETn    = 1'b1;
        push_exp(2);
        push_exp(3);
        drain(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
